// File: rtl/ws_pixel_tx.sv
// WS2812B/WS2811 strip driver: two-bank pixel RAM, runtime-selectable bit timing, latch gap.
// Define WS_PIX_BRIGHT_EN to add the bright[7:0] input and per-colour brightness scaling.
module ws_pixel_tx #(
  parameter int PIX_BITS  = 24,
  parameter int ADDR_W    = 9,
  parameter int F_TBIT    = 25,
  parameter int F_T0H     = 8,
  parameter int F_T1H     = 16,
  parameter int S_TBIT    = 50,
  parameter int S_T0H     = 10,
  parameter int S_T1H     = 24,
  parameter int RESET_CYC = 1200
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [PIX_BITS-1:0] wr_data,
  input  logic                start,
  input  logic                bank,
  input  logic [ADDR_W-1:0]   leds,
  input  logic                mode,
`ifdef WS_PIX_BRIGHT_EN
  input  logic [7:0]          bright,
`endif
  output logic                busy,
  output logic                done,
  output logic                tx_out
);

  localparam int MAX_TBIT = (S_TBIT > F_TBIT) ? S_TBIT : F_TBIT;
  localparam int MAX_CYC  = (RESET_CYC > MAX_TBIT) ? RESET_CYC : MAX_TBIT;
  localparam int CNT_W    = $clog2(MAX_CYC + 1);
  localparam int BIT_W    = $clog2(PIX_BITS);
  localparam int PIX_W    = ADDR_W - 1;
  localparam logic [ADDR_W-1:0] BANK_PIX = {1'b1, {PIX_W{1'b0}}};

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_BIT  = 3'd2;
  localparam logic [2:0] ST_GAP  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [PIX_BITS-1:0] mem [2**ADDR_W];
  logic [PIX_BITS-1:0] rd_data_r;
  logic [PIX_BITS-1:0] sh_r;
  logic [PIX_BITS-1:0] word_s;
  logic [2:0]          state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_inc_s;
  logic [CNT_W-1:0]    tbit_m1_s;
  logic [CNT_W-1:0]    t0h_s;
  logic [CNT_W-1:0]    t1h_s;
  logic [CNT_W-1:0]    txh_s;
  logic [BIT_W-1:0]    bit_r;
  logic [PIX_W-1:0]    pix_r;
  logic [ADDR_W-1:0]   rem_r;
  logic [ADDR_W-1:0]   leds_clamp_s;
  logic                bank_r;
  logic                mode_r;
  logic                busy_r;
  logic                done_r;
  logic                tx_r;
`ifdef WS_PIX_BRIGHT_EN
  logic [7:0]          bright_r;

  function automatic logic [PIX_BITS-1:0] scale_word(input logic [PIX_BITS-1:0] w,
                                                     input logic [7:0] b);
    logic [15:0] prod;
    scale_word = w;
    for (int f = 0; f < PIX_BITS / 8; f++) begin
      prod = 16'(w[f*8 +: 8]) * (16'(b) + 16'd1);
      scale_word[f*8 +: 8] = prod[15:8];
    end
  endfunction
`endif

  assign busy   = busy_r;
  assign done   = done_r;
  assign tx_out = tx_r;

  // Timing selection for the latched mode, input clamping and the word about to be shifted out.
  always_comb begin
    if (mode_r) begin
      tbit_m1_s = CNT_W'(S_TBIT - 1);
      t0h_s     = CNT_W'(S_T0H);
      t1h_s     = CNT_W'(S_T1H);
    end else begin
      tbit_m1_s = CNT_W'(F_TBIT - 1);
      t0h_s     = CNT_W'(F_T0H);
      t1h_s     = CNT_W'(F_T1H);
    end
    if (sh_r[PIX_BITS-1]) begin
      txh_s = t1h_s;
    end else begin
      txh_s = t0h_s;
    end
    if (leds > BANK_PIX) begin
      leds_clamp_s = BANK_PIX;
    end else begin
      leds_clamp_s = leds;
    end
    cnt_inc_s = cnt_r + CNT_W'(1);
`ifdef WS_PIX_BRIGHT_EN
    word_s = scale_word(rd_data_r, bright_r);
`else
    word_s = rd_data_r;
`endif
  end

  // Pixel RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port runs every cycle on the next pixel to send, so data waits ready at each pixel boundary.
  always_ff @(posedge clk) begin
    rd_data_r <= mem[{bank_r, pix_r}];
  end

  // Frame sequencer: the edge that ends a bit also decides the level of the next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      tx_r    <= 1'b0;
      cnt_r   <= '0;
      bit_r   <= '0;
      pix_r   <= '0;
      rem_r   <= '0;
      sh_r    <= '0;
      bank_r  <= 1'b0;
      mode_r  <= 1'b0;
`ifdef WS_PIX_BRIGHT_EN
      bright_r <= 8'd0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start && (leds != '0)) begin
            state_r <= ST_LOAD;
            busy_r  <= 1'b1;
            bank_r  <= bank;
            mode_r  <= mode;
            rem_r   <= leds_clamp_s;
            pix_r   <= '0;
`ifdef WS_PIX_BRIGHT_EN
            bright_r <= bright;
`endif
          end
        end
        ST_LOAD: begin
          // Pretend a previous pixel just ended so BIT loads pixel 0 on its first edge.
          state_r <= ST_BIT;
          cnt_r   <= tbit_m1_s;
          bit_r   <= '0;
        end
        ST_BIT: begin
          if (cnt_r == tbit_m1_s) begin
            cnt_r <= '0;
            if (bit_r == '0) begin
              if (rem_r != '0) begin
                sh_r  <= word_s;
                bit_r <= BIT_W'(PIX_BITS - 1);
                rem_r <= rem_r - ADDR_W'(1);
                pix_r <= pix_r + PIX_W'(1);
                tx_r  <= 1'b1;
              end else begin
                state_r <= ST_GAP;
                tx_r    <= 1'b0;
              end
            end else begin
              sh_r  <= sh_r << 1;
              bit_r <= bit_r - BIT_W'(1);
              tx_r  <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_inc_s;
            tx_r  <= (cnt_inc_s < txh_s);
          end
        end
        ST_GAP: begin
          tx_r <= 1'b0;
          if (cnt_r == CNT_W'(RESET_CYC - 1)) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          tx_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws_pixel_tx.sv
// Self-checking bench for ws_pixel_tx: randomized frames compared cycle by cycle with a waveform model.
// Build with +define+WS_PIX_BRIGHT_EN to also cover brightness scaling.
module tb_ws_pixel_tx;

  localparam int TB_PIX    = 24;
  localparam int TB_ADDR_W = 9;
  localparam int TB_F_TBIT = 8;
  localparam int TB_F_T0H  = 2;
  localparam int TB_F_T1H  = 5;
  localparam int TB_S_TBIT = 16;
  localparam int TB_S_T0H  = 3;
  localparam int TB_S_T1H  = 8;
  localparam int TB_RESET  = 40;
  localparam int HALF      = 2 ** (TB_ADDR_W - 1);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 wr;
  logic [TB_ADDR_W-1:0] wr_addr;
  logic [TB_PIX-1:0]    wr_data;
  logic                 start;
  logic                 bank;
  logic [TB_ADDR_W-1:0] leds;
  logic                 mode;
  logic [7:0]           bright;
  logic                 busy;
  logic                 done;
  logic                 tx_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [TB_PIX-1:0] mem_model [2**TB_ADDR_W];
  logic [2:0]        exp_q[$];
  logic [2:0]        obs_q[$];

  ws_pixel_tx #(
    .PIX_BITS(TB_PIX), .ADDR_W(TB_ADDR_W),
    .F_TBIT(TB_F_TBIT), .F_T0H(TB_F_T0H), .F_T1H(TB_F_T1H),
    .S_TBIT(TB_S_TBIT), .S_T0H(TB_S_T0H), .S_T1H(TB_S_T1H),
    .RESET_CYC(TB_RESET)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .bank(bank), .leds(leds), .mode(mode),
`ifdef WS_PIX_BRIGHT_EN
    .bright(bright),
`endif
    .busy(busy), .done(done), .tx_out(tx_out)
  );

  always #5 clk = ~clk;

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached, got no $finish, required completion");
    $fatal(1, "watchdog");
  end

  function automatic int eff_br(input int br);
`ifdef WS_PIX_BRIGHT_EN
    return br;
`else
    return 255;
`endif
  endfunction

  // Each 8-bit colour field becomes floor(c*(br+1)/256); br=255 leaves the word unchanged.
  function automatic logic [TB_PIX-1:0] model_word(input logic [TB_PIX-1:0] w, input int br);
    logic [TB_PIX-1:0] r;
    int c;
    for (int f = 0; f < TB_PIX / 8; f++) begin
      c = int'(w[8*f +: 8]);
      r[8*f +: 8] = 8'((c * (br + 1)) / 256);
    end
    return r;
  endfunction

  // Expected {tx,busy,done} for every cycle from the one after the accepting edge to the idle cycle after done.
  task automatic build_exp(input int n_req, input bit bk, input bit md, input int br);
    int n, tbit, hi;
    logic [TB_PIX-1:0] w;
    n    = (n_req > HALF) ? HALF : n_req;
    tbit = md ? TB_S_TBIT : TB_F_TBIT;
    exp_q.delete();
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b010);
    for (int p = 0; p < n; p++) begin
      w = model_word(mem_model[int'(bk) * HALF + p], br);
      for (int b = TB_PIX - 1; b >= 0; b--) begin
        hi = w[b] ? (md ? TB_S_T1H : TB_F_T1H) : (md ? TB_S_T0H : TB_F_T0H);
        for (int c = 0; c < tbit; c++) exp_q.push_back((c < hi) ? 3'b110 : 3'b010);
      end
    end
    for (int c = 0; c < TB_RESET; c++) exp_q.push_back(3'b010);
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b000);
  endtask

  // Pulse start, scramble the frame inputs afterwards, record exp_q.size() cycles; optional extra start pulse.
  task automatic run_frame(input int n_req, input bit bk, input bit md, input int br, input int inject_idx);
    obs_q.delete();
    leds = TB_ADDR_W'(n_req); bank = bk; mode = md; bright = 8'(br); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    leds = TB_ADDR_W'($urandom); bank = 1'($urandom); mode = 1'($urandom); bright = 8'($urandom);
    for (int i = 0; i < exp_q.size(); i++) begin
      obs_q.push_back({tx_out, busy, done});
      start = (i == inject_idx);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  function automatic int first_diff();
    for (int i = 0; i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic write_pix(input int addr, input logic [TB_PIX-1:0] data);
    wr = 1'b1; wr_addr = TB_ADDR_W'(addr); wr_data = data;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0;
    mem_model[addr] = data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr = 1'b0; start = 1'b0; bank = 1'b0; mode = 1'b0;
    leds = '0; wr_addr = '0; wr_data = '0; bright = 8'd255;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx_out, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_state: {tx,busy,done} got %b expected 000", {tx_out, busy, done});
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2 ** TB_ADDR_W; i++) write_pix(i, TB_PIX'($urandom));
  endtask

  task automatic test_fast_timing();
    int d, w1, w0;
    write_pix(0, 24'hFF0000);
    build_exp(1, 1'b0, 1'b0, eff_br(255));
    run_frame(1, 1'b0, 1'b0, 255, -1);
    d = first_diff();
    n_checks++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL fast_wave: cycle %0d {tx,busy,done} got %b expected %b", d, obs_q[d], exp_q[d]);
    end
    w1 = 0; w0 = 0;
    for (int i = 2; i < 2 + TB_F_TBIT; i++) w1 += int'(obs_q[i][2]);
    for (int i = 2 + 8 * TB_F_TBIT; i < 2 + 9 * TB_F_TBIT; i++) w0 += int'(obs_q[i][2]);
    n_checks++;
    if (w1 != TB_F_T1H) begin
      n_fail++;
      $display("FAIL fast_one_high: got %0d cycles expected %0d", w1, TB_F_T1H);
    end
    n_checks++;
    if (w0 != TB_F_T0H) begin
      n_fail++;
      $display("FAIL fast_zero_high: got %0d cycles expected %0d", w0, TB_F_T0H);
    end
  endtask

  task automatic test_slow_multi();
    int d, nbusy;
    for (int p = 0; p < 3; p++) write_pix(p, 24'hAAAAAA);
    build_exp(3, 1'b0, 1'b1, eff_br(255));
    run_frame(3, 1'b0, 1'b1, 255, -1);
    d = first_diff();
    n_checks++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL slow_wave: cycle %0d {tx,busy,done} got %b expected %b", d, obs_q[d], exp_q[d]);
    end
    nbusy = 0;
    foreach (obs_q[i]) nbusy += int'(obs_q[i][1]);
    n_checks++;
    if (nbusy != 72 * TB_S_TBIT + TB_RESET + 2) begin
      n_fail++;
      $display("FAIL slow_busy_len: got %0d expected %0d", nbusy, 72 * TB_S_TBIT + TB_RESET + 2);
    end
  endtask

  task automatic test_bank_select();
    int d;
    write_pix(0, 24'h000001);
    write_pix(HALF, 24'h800000);
    build_exp(1, 1'b1, 1'b0, eff_br(255));
    run_frame(1, 1'b1, 1'b0, 255, -1);
    d = first_diff();
    n_checks++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL bank_wave: cycle %0d {tx,busy,done} got %b expected %b", d, obs_q[d], exp_q[d]);
    end
  endtask

  task automatic test_ignored_starts();
    int d, ndone, seen;
    build_exp(2, 1'b0, 1'b0, eff_br(200));
    run_frame(2, 1'b0, 1'b0, 200, 2 + 3 * TB_F_TBIT);
    d = first_diff();
    ndone = 0;
    foreach (obs_q[i]) ndone += int'(obs_q[i][0]);
    n_checks++;
    if (d != -1 || ndone != 1) begin
      n_fail++;
      $display("FAIL start_mid_frame: diff at %0d done pulses got %0d expected 1", d, ndone);
    end
    build_exp(1, 1'b1, 1'b1, eff_br(90));
    run_frame(1, 1'b1, 1'b1, 90, exp_q.size() - 2);
    d = first_diff();
    n_checks++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL start_in_done: cycle %0d got %b expected %b", d, obs_q[d], exp_q[d]);
    end
    leds = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    repeat (30) begin
      seen += int'(busy) + int'(done);
      @(negedge clk);
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL start_zero_leds: busy/done cycles got %0d expected 0", seen);
    end
  endtask

  task automatic test_clamp();
    int d;
    build_exp(511, 1'b0, 1'b0, eff_br(255));
    run_frame(511, 1'b0, 1'b0, 255, -1);
    d = first_diff();
    n_checks++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL clamp_wave: cycle %0d {tx,busy,done} got %b expected %b", d, obs_q[d], exp_q[d]);
    end
  endtask

  task automatic test_reset_mid_frame();
    int d;
    leds = TB_ADDR_W'(2); bank = 1'b0; mode = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2 + 5 * TB_F_TBIT + 2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_before_reset: got %b expected 1", busy);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({tx_out, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_frame: {tx,busy,done} got %b expected 000", {tx_out, busy, done});
    end
    rst_n = 1'b1;
    @(negedge clk);
    build_exp(2, 1'b0, 1'b0, eff_br(255));
    run_frame(2, 1'b0, 1'b0, 255, -1);
    d = first_diff();
    n_checks++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL replay_after_reset: cycle %0d got %b expected %b", d, obs_q[d], exp_q[d]);
    end
  endtask

  task automatic test_random_frames();
    int d, n, br;
    bit bk, md;
    for (int t = 0; t < 5; t++) begin
      n  = $urandom_range(1, 3);
      bk = 1'($urandom);
      md = 1'($urandom);
      br = $urandom_range(0, 255);
      for (int p = 0; p < n; p++) write_pix(int'(bk) * HALF + p, TB_PIX'($urandom));
      build_exp(n, bk, md, eff_br(br));
      run_frame(n, bk, md, br, -1);
      d = first_diff();
      n_checks++;
      if (d != -1) begin
        n_fail++;
        $display("FAIL random_frame_%0d: cycle %0d got %b expected %b", t, d, obs_q[d], exp_q[d]);
      end
    end
  endtask

`ifdef WS_PIX_BRIGHT_EN
  task automatic test_bright();
    int d;
    int br_list[2] = '{127, 255};
    write_pix(0, 24'hFF8040);
    foreach (br_list[k]) begin
      build_exp(1, 1'b0, 1'b0, br_list[k]);
      run_frame(1, 1'b0, 1'b0, br_list[k], -1);
      d = first_diff();
      n_checks++;
      if (d != -1) begin
        n_fail++;
        $display("FAIL bright_%0d: cycle %0d got %b expected %b", br_list[k], d, obs_q[d], exp_q[d]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fast_timing();
    test_slow_multi();
    test_bank_select();
    test_ignored_starts();
    test_reset_mid_frame();
    test_random_frames();
`ifdef WS_PIX_BRIGHT_EN
    test_bright();
`endif
    test_clamp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
